// File: rtl/framebuffer_scanout_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the framebuffer scan-out block.
package scanout_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_BLANK    = 3'd4,
        ST_LATCH    = 3'd5,
        ST_DISPLAY  = 3'd6
    } scan_state_e;

    // Column counter width for a power-of-two panel width (at least one bit).
    function automatic int col_bits(input int width);
        if (width <= 2) begin
            return 1;
        end else begin
            return $clog2(width);
        end
    endfunction

endpackage

// File: rtl/framebuffer_scanout_if.sv
`timescale 1ns/1ps
// RAM read port and panel pin bundle between the scan-out engine and its surroundings.
interface framebuffer_scanout_if #(
    parameter int ROW_BITS = 5
);
    import scanout_pkg::*;

    logic                Enable;
    logic [ADDR_W-1:0]   RamAddress;
    logic                RamClockEn;
    logic [DATA_W-1:0]   RamData;
    logic                PanelClk;
    logic [DATA_W-1:0]   PanelData;
    logic                PanelLatch;
    logic                PanelOe_n;
    logic [ROW_BITS-1:0] PanelRow;
    logic                FrameStart;
    logic                Busy;

    // The scan-out engine drives the RAM address side and all panel pins.
    modport master (
        input  Enable,
        input  RamData,
        output RamAddress,
        output RamClockEn,
        output PanelClk,
        output PanelData,
        output PanelLatch,
        output PanelOe_n,
        output PanelRow,
        output FrameStart,
        output Busy
    );

    // The environment supplies the run enable and the RAM read data.
    modport slave (
        output Enable,
        output RamData,
        input  RamAddress,
        input  RamClockEn,
        input  PanelClk,
        input  PanelData,
        input  PanelLatch,
        input  PanelOe_n,
        input  PanelRow,
        input  FrameStart,
        input  Busy
    );

endinterface

// File: rtl/scan_oe_timer.sv
`timescale 1ns/1ps
// Loadable down-counter that times the output-enable window of one row.
module scan_oe_timer #(
    parameter int COUNT_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               load_i,
    input  logic [COUNT_W-1:0] load_val_i,
    input  logic               dec_i,
    output logic               done_o
);

    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    // Load takes priority; otherwise count down while enabled, stopping at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != {COUNT_W{1'b0}})) begin
            count_d = count_q - COUNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count_q <= {COUNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == {COUNT_W{1'b0}});

endmodule

// File: rtl/framebuffer_scanout.sv
`timescale 1ns/1ps
// Reads the framebuffer one column at a time, shifts each row out to a
// HUB75-style panel, latches it, selects the row and lights it for a
// programmable number of clocks.
module framebuffer_scanout
    import scanout_pkg::*;
#(
    parameter int PANEL_WIDTH   = 64,
    parameter int ROW_BITS      = 5,
    parameter int BRIGHT_CYCLES = 16
) (
    input logic                   Clock,
    input logic                   Reset,
    framebuffer_scanout_if.master bus
);

    localparam int COL_W = col_bits(PANEL_WIDTH);
    localparam int OE_W  = (BRIGHT_CYCLES > 1) ? $clog2(BRIGHT_CYCLES) : 1;

    localparam logic [COL_W-1:0]    COL_LAST = COL_W'(PANEL_WIDTH - 1);
    localparam logic [COL_W-1:0]    COL_ZERO = {COL_W{1'b0}};
    localparam logic [COL_W-1:0]    COL_ONE  = COL_W'(1);
    localparam logic [ROW_BITS-1:0] ROW_ZERO = {ROW_BITS{1'b0}};
    localparam logic [ROW_BITS-1:0] ROW_ONE  = ROW_BITS'(1);
    localparam logic [OE_W-1:0]     OE_LOAD  = OE_W'(BRIGHT_CYCLES - 1);

    scan_state_e         state_q, state_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                ce_q, ce_d;
    logic                pclk_q, pclk_d;
    logic [DATA_W-1:0]   pdata_q, pdata_d;
    logic                latch_q, latch_d;
    logic                oe_n_q, oe_n_d;
    logic [ROW_BITS-1:0] prow_q, prow_d;
    logic                fs_q, fs_d;
    logic                busy_q, busy_d;

    logic                timer_load_s;
    logic                timer_done_s;

    scan_oe_timer #(
        .COUNT_W (OE_W)
    ) u_oe_timer (
        .clk_i      (Clock),
        .rst_n_i    (Reset),
        .load_i     (timer_load_s),
        .load_val_i (OE_LOAD),
        .dec_i      (state_q == ST_DISPLAY),
        .done_o     (timer_done_s)
    );

    // Next-state and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        addr_d       = addr_q;
        pdata_d      = pdata_q;
        prow_d       = prow_q;
        fs_d         = 1'b0;
        timer_load_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.Enable) begin
                    state_d = ST_FETCH;
                    addr_d  = ADDR_W'({row_q, COL_ZERO});
                    fs_d    = (row_q == ROW_ZERO);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_d = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: begin
                // Prefetch the next column; at the last column this wraps to
                // column 0 of the same row, a harmless redundant read.
                pdata_d = bus.RamData;
                addr_d  = ADDR_W'({row_q, col_q + COL_ONE});
                state_d = ST_SHIFT_HI;
            end
            ST_SHIFT_HI: begin
                if (col_q == COL_LAST) begin
                    col_d   = COL_ZERO;
                    state_d = ST_BLANK;
                end else begin
                    col_d   = col_q + COL_ONE;
                    state_d = ST_SHIFT_LO;
                end
            end
            ST_BLANK: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                prow_d       = row_q;
                timer_load_s = 1'b1;
                state_d      = ST_DISPLAY;
            end
            ST_DISPLAY: begin
                if (timer_done_s) begin
                    row_d = row_q + ROW_ONE;
                    if (bus.Enable) begin
                        state_d = ST_FETCH;
                        addr_d  = ADDR_W'({row_q + ROW_ONE, COL_ZERO});
                        fs_d    = ((row_q + ROW_ONE) == ROW_ZERO);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_DISPLAY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ce_d    = (state_d == ST_FETCH) || (state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI);
        pclk_d  = (state_d == ST_SHIFT_HI);
        latch_d = (state_d == ST_LATCH);
        oe_n_d  = (state_d != ST_DISPLAY);
        busy_d  = (state_d != ST_IDLE);
    end

    // State, counters and registered outputs; reset aborts any row in progress.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            row_q   <= ROW_ZERO;
            col_q   <= COL_ZERO;
            addr_q  <= {ADDR_W{1'b0}};
            ce_q    <= 1'b0;
            pclk_q  <= 1'b0;
            pdata_q <= {DATA_W{1'b0}};
            latch_q <= 1'b0;
            oe_n_q  <= 1'b1;
            prow_q  <= ROW_ZERO;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
            ce_q    <= ce_d;
            pclk_q  <= pclk_d;
            pdata_q <= pdata_d;
            latch_q <= latch_d;
            oe_n_q  <= oe_n_d;
            prow_q  <= prow_d;
            fs_q    <= fs_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.RamAddress = addr_q;
    assign bus.RamClockEn = ce_q;
    assign bus.PanelClk   = pclk_q;
    assign bus.PanelData  = pdata_q;
    assign bus.PanelLatch = latch_q;
    assign bus.PanelOe_n  = oe_n_q;
    assign bus.PanelRow   = prow_q;
    assign bus.FrameStart = fs_q;
    assign bus.Busy       = busy_q;

endmodule

// File: tb/tb_framebuffer_scanout.sv
`timescale 1ns/1ps
// Scoreboard bench: a default-size panel plus a 2-wide, 1-clock-bright corner instance.
module tb_framebuffer_scanout;
    import scanout_pkg::*;

    logic clk;
    logic rst_n;

    framebuffer_scanout_if #(.ROW_BITS(5)) bus ();
    framebuffer_scanout_if #(.ROW_BITS(5)) bus2 ();

    framebuffer_scanout #(.PANEL_WIDTH(64), .ROW_BITS(5), .BRIGHT_CYCLES(16)) dut (
        .Clock (clk), .Reset (rst_n), .bus (bus)
    );
    framebuffer_scanout #(.PANEL_WIDTH(2), .ROW_BITS(5), .BRIGHT_CYCLES(1)) dut2 (
        .Clock (clk), .Reset (rst_n), .bus (bus2)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int exp_pix[$];
    int exp_row[$];
    int exp_pix2[$];
    int fs_cyc[$];
    int latch_cnt  = 0;
    int latch2_cnt = 0;
    int oe_run     = 0;
    int oe2_run    = 0;
    int shifts2    = 0;
    int last_latch2 = -1;
    int e_tmp;

    logic prev_pclk = 1'b0, prev_latch = 1'b0, prev_oe_n = 1'b1, prev_fs = 1'b0;
    logic prev_pclk2 = 1'b0, prev_oe2_n = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Simple synchronous RAM models: main cell {r,c} holds c[1:0]^r[1:0]; corner holds addr[1:0].
    always @(posedge clk) begin
        if (bus.RamClockEn) bus.RamData <= bus.RamAddress[1:0] ^ bus.RamAddress[7:6];
        if (bus2.RamClockEn) bus2.RamData <= bus2.RamAddress[1:0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] outs_main();
        return 32'({bus.RamAddress, bus.RamClockEn, bus.PanelClk, bus.PanelData, bus.PanelLatch,
                    bus.PanelOe_n, bus.PanelRow, bus.FrameStart, bus.Busy});
    endfunction

    function automatic logic [31:0] outs_small();
        return 32'({bus2.RamAddress, bus2.RamClockEn, bus2.PanelClk, bus2.PanelData, bus2.PanelLatch,
                    bus2.PanelOe_n, bus2.PanelRow, bus2.FrameStart, bus2.Busy});
    endfunction

    function automatic logic [31:0] get_val(input int which);
        case (which)
            0: return 32'(fs_cyc.size());
            1: return 32'(latch_cnt);
            2: return 32'(latch2_cnt);
            3: return 32'(bus.Busy);
            4: return 32'(bus.RamAddress);
            5: return 32'(bus2.Busy);
            default: return 32'd0;
        endcase
    endfunction

    task automatic wait_val(input string name, input int which, input logic [31:0] target, input int budget);
        int k;
        k = 0;
        while (get_val(which) !== target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(name, get_val(which), target);
    endtask

    task automatic push_row(input int r);
        for (int c = 0; c < 64; c++) exp_pix.push_back((c ^ r) & 3);
        exp_row.push_back(r & 31);
    endtask

    // Monitor for the main panel: pixel stream, latch row, OE window, FrameStart.
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
            if (bus.PanelClk === 1'b1 && prev_pclk !== 1'b1) begin
                if (exp_pix.size() == 0) check("pix_unexpected", 32'd1, 32'd0);
                else begin
                    e_tmp = exp_pix.pop_front();
                    check("pixel", 32'(bus.PanelData), 32'(e_tmp));
                end
            end
            if (prev_latch) begin
                check("latch_width", 32'(bus.PanelLatch), 32'd0);
                if (exp_row.size() == 0) check("latch_unexpected", 32'd1, 32'd0);
                else begin
                    e_tmp = exp_row.pop_front();
                    check("latch_row", 32'(bus.PanelRow), 32'(e_tmp));
                end
            end
            if (bus.PanelLatch === 1'b1) latch_cnt++;
            if (bus.PanelOe_n === 1'b0) begin
                oe_run++;
                check("latch_while_oe", 32'(bus.PanelLatch), 32'd0);
            end
            if (bus.PanelOe_n === 1'b1 && prev_oe_n === 1'b0) begin
                check("oe_low_clks", 32'(oe_run), 32'd16);
                oe_run = 0;
            end
            if (prev_fs) check("fs_width", 32'(bus.FrameStart), 32'd0);
            if (bus.FrameStart === 1'b1) fs_cyc.push_back(cyc);
        end else begin
            oe_run = 0;
        end
        prev_pclk  = bus.PanelClk;
        prev_latch = bus.PanelLatch;
        prev_oe_n  = bus.PanelOe_n;
        prev_fs    = bus.FrameStart;
    end

    // Monitor for the corner panel: pixels, shifts per row, row period, OE window.
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
            if (bus2.PanelClk === 1'b1 && prev_pclk2 !== 1'b1) begin
                shifts2++;
                if (exp_pix2.size() == 0) check("pix2_unexpected", 32'd1, 32'd0);
                else begin
                    e_tmp = exp_pix2.pop_front();
                    check("pixel2", 32'(bus2.PanelData), 32'(e_tmp));
                end
            end
            if (bus2.PanelLatch === 1'b1) begin
                latch2_cnt++;
                check("shifts_per_row2", 32'(shifts2), 32'd2);
                shifts2 = 0;
                if (last_latch2 >= 0) check("row_period2", 32'(cyc - last_latch2), 32'd8);
                last_latch2 = cyc;
            end
            if (bus2.PanelOe_n === 1'b0) oe2_run++;
            if (bus2.PanelOe_n === 1'b1 && prev_oe2_n === 1'b0) begin
                check("oe_low_clks2", 32'(oe2_run), 32'd1);
                oe2_run = 0;
            end
        end
        prev_pclk2 = bus2.PanelClk;
        prev_oe2_n = bus2.PanelOe_n;
    end

    // Directed stimulus sequence.
    initial begin
        rst_n = 1'b0;
        bus.Enable  = 1'b0;
        bus2.Enable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset and idle: everything at reset values with only PanelOe_n high.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check("reset_idle", outs_main(), 32'h80);
            check("reset_idle2", outs_small(), 32'h80);
        end

        // Single row, then 33 rows with wrap; second FrameStart one frame later.
        for (int r = 0; r < 33; r++) push_row(r);
        bus.Enable = 1'b1;
        wait_val("wait_fs2", 0, 32'd2, 6000);
        bus.Enable = 1'b0;
        wait_val("wait_idle_wrap", 3, 32'd0, 400);
        check("latches_33", 32'(latch_cnt), 32'd33);
        check("fs_count", 32'(fs_cyc.size()), 32'd2);
        if (fs_cyc.size() >= 2) check("frame_period", 32'(fs_cyc[1] - fs_cyc[0]), 32'd4704);

        // Mid-row disable during column 10 of row 3.
        for (int r = 1; r < 4; r++) push_row(r);
        bus.Enable = 1'b1;
        wait_val("wait_r3c10", 4, 32'd202, 800);
        bus.Enable = 1'b0;
        wait_val("wait_idle_r3", 3, 32'd0, 400);
        check("latches_after_r3", 32'(latch_cnt), 32'd36);
        check("pix_drained_r3", 32'(exp_pix.size()), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("idle_oe_busy", 32'({bus.PanelOe_n, bus.Busy}), 32'h2);
        end

        // Re-enable resumes at row 4; reset at column 40 aborts it.
        push_row(4);
        bus.Enable = 1'b1;
        wait_val("wait_busy_r4", 3, 32'd1, 5);
        check("resume_row4", 32'({bus.FrameStart, bus.RamAddress}), 32'd256);
        wait_val("wait_r4c40", 4, 32'd296, 200);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_pix.delete();
        exp_row.delete();
        @(negedge clk);
        #1;
        check("reset_midshift", outs_main(), 32'h80);
        check("no_partial_latch", 32'(latch_cnt), 32'd36);
        push_row(0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("restart_fetch", 32'({bus.FrameStart, bus.RamAddress}), 32'h800);
        wait_val("wait_latch_restart", 1, 32'd37, 300);
        bus.Enable = 1'b0;
        wait_val("wait_idle_restart", 3, 32'd0, 200);
        check("fs_after_reset", 32'(fs_cyc.size()), 32'd3);
        check("pix_drained_restart", 32'(exp_pix.size()), 32'd0);

        // Corner instance: 2 columns, 1 bright clock, 8-clock row period.
        exp_pix2 = '{0, 1, 2, 3, 0, 1};
        bus2.Enable = 1'b1;
        wait_val("wait_latch2", 2, 32'd3, 60);
        bus2.Enable = 1'b0;
        wait_val("wait_idle2", 5, 32'd0, 30);
        check("pix2_drained", 32'(exp_pix2.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
